// File: rtl/uart_receiver.sv
// uart_receiver
//   Receive side of the UART link. Synchronizes the asynchronous Rx line,
//   finds the start bit, samples each bit at mid-bit and presents each good
//   byte behind a valid/ack handshake. Frame: 1 start, 8 data (LSB first),
//   optional even-parity bit, 1 stop.
//
//   Build option: define UART_RX_PARITY_EN to expect and check an even-parity
//   bit after data bit 7. Without it Parity_err is tied low.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   Rx           serial line, idle high, asynchronous to clk
//   Byte_ack     consumer accepts Data_Out (only meaningful while Byte_valid)
//   Data_Out     last received byte, stable while Byte_valid
//   Byte_valid   byte available level
//   Framing_err  one-cycle pulse, stop bit sampled low
//   Parity_err   one-cycle pulse, parity mismatch
//   Overrun_err  one-cycle pulse, byte completed while previous unacknowledged
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | half a bit period, then confirm the start bit
// DATA   | sample 8 data bits, one per bit period
// PARITY | sample the parity bit (parity build only)
// STOP   | sample the stop bit, commit or discard the byte
// BREAK  | line held low after a framing error, wait for it to go high
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx,
  input  logic       Byte_ack,
  output logic [7:0] Data_Out,
  output logic       Byte_valid,
  output logic       Framing_err,
  output logic       Parity_err,
  output logic       Overrun_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, rx_s_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, oerr_q, oerr_d;
  logic            done, frame_err;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            perr_q, par_err;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    done      = 1'b0;
    frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    par_err   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          idx_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          // a start bit that is gone at mid-bit was a glitch
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          par_d   = rx_s_q;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          frame_err = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
          par_err   = ((^shift_q) != par_q);
          done      = ~frame_err & ~par_err;
`else
          done      = ~frame_err;
`endif
          // returning to IDLE at mid stop bit allows zero-gap frames
          state_d   = frame_err ? S_BREAK : S_IDLE;
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    oerr_d  = 1'b0;
    if (done) begin
      // an ack in the completion cycle frees the holding register
      if (!valid_q || Byte_ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        oerr_d = 1'b1;
      end
    end else if (valid_q && Byte_ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      sync1_q <= Rx;
      rx_s_q  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= frame_err;
      oerr_q  <= oerr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= par_err;
    end
  end
  assign Parity_err = perr_q;
`else
  assign Parity_err = 1'b0;
`endif

  assign Data_Out    = data_q;
  assign Byte_valid  = valid_q;
  assign Framing_err = ferr_q;
  assign Overrun_err = oerr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver: directed cases plus randomized frames, all
// outputs compared every cycle against a frame-timing reference model.
module tb_uart_receiver;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_BITS = 10 + PAR;
  // Rx fall to Byte_valid: 2 sync + half bit + (9|10) bits + output register
  localparam int LAT = 2 + H + (9 + PAR) * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Rx = 1'b1;
  logic       Byte_ack = 1'b0;
  logic [7:0] Data_Out;
  logic       Byte_valid, Framing_err, Parity_err, Overrun_err;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .Rx(Rx), .Byte_ack(Byte_ack),
    .Data_Out(Data_Out), .Byte_valid(Byte_valid),
    .Framing_err(Framing_err), .Parity_err(Parity_err),
    .Overrun_err(Overrun_err)
  );

  always #5 clk = ~clk;

  int n_chk_m = 0, n_fail_m = 0;
  int n_chk_d = 0, n_fail_d = 0;
  int cyc = 0;
  int ack_at = -1;
  bit rand_en = 1'b0;
  bit chk_en = 1'b0;

  // reference model state
  logic       m_r1 = 1'b1, m_r2 = 1'b1, s;
  bit         busy = 1'b0, brk = 1'b0, done, fe, pe;
  int         off = 0;
  logic [7:0] m_bits = 8'h00;
  logic       m_pbit = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0, m_ferr = 1'b0, m_perr = 1'b0, m_oerr = 1'b0;

  always @(posedge clk) begin
    cyc++;
    m_ferr = 1'b0; m_perr = 1'b0; m_oerr = 1'b0;
    if (rst) begin
      m_r1 = 1'b1; m_r2 = 1'b1; busy = 1'b0; brk = 1'b0; off = 0;
      m_valid = 1'b0; m_data = 8'h00;
    end else begin
      s = m_r2; m_r2 = m_r1; m_r1 = Rx;
      done = 1'b0;
      if (brk) begin
        if (s) brk = 1'b0;
      end else if (!busy) begin
        if (!s) begin busy = 1'b1; off = 0; end
      end else begin
        off++;
        if (off == H) begin
          if (s) busy = 1'b0;
        end else if (off > H && off <= H + 8 * CPB && ((off - H) % CPB) == 0) begin
          m_bits[(off - H) / CPB - 1] = s;
        end else if (PAR == 1 && off == H + 9 * CPB) begin
          m_pbit = s;
        end else if (off == H + (9 + PAR) * CPB) begin
          fe = !s;
          pe = (PAR == 1) && (m_pbit != ^m_bits);
          m_ferr = fe; m_perr = pe;
          busy = 1'b0;
          if (fe) brk = 1'b1;
          done = !fe && !pe;
        end
      end
      if (done) begin
        if (!m_valid || Byte_ack) begin m_data = m_bits; m_valid = 1'b1; end
        else m_oerr = 1'b1;
      end else if (m_valid && Byte_ack) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic chk_m(input string name, input int act, input int exp);
    n_chk_m++;
    if (act != exp) begin
      n_fail_m++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_d(input string name, input int act, input int exp);
    n_chk_d++;
    if (act != exp) begin
      n_fail_d++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  int  ferr_cnt = 0, perr_cnt = 0, oerr_cnt = 0, t_rise = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk_m("Data_Out",    int'(Data_Out),    int'(m_data));
      chk_m("Byte_valid",  int'(Byte_valid),  int'(m_valid));
      chk_m("Framing_err", int'(Framing_err), int'(m_ferr));
      chk_m("Parity_err",  int'(Parity_err),  int'(m_perr));
      chk_m("Overrun_err", int'(Overrun_err), int'(m_oerr));
    end
    if (Framing_err === 1'b1) ferr_cnt++;
    if (Parity_err === 1'b1)  perr_cnt++;
    if (Overrun_err === 1'b1) oerr_cnt++;
    if (Byte_valid === 1'b1 && prev_valid !== 1'b1) t_rise = cyc;
    prev_valid = Byte_valid;
  end

  always @(negedge clk) begin
    #2;
    Byte_ack = (cyc == ack_at) || (rand_en && ($urandom_range(0, 3) == 0));
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop_v,
                           input logic pflip, input int nbits);
    logic [10:0] fr;
    fr = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < 8; i++) fr[i + 1] = b[i];
    if (PAR == 1) begin
      fr[9]  = (^b) ^ pflip;
      fr[10] = stop_v;
    end else begin
      fr[9] = stop_v;
    end
    for (int i = 0; i < nbits && i < FRAME_BITS; i++) begin
      Rx = fr[i];
      repeat (CPB) tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bits(b, 1'b1, 1'b0, FRAME_BITS);
    Rx = 1'b1;
  endtask

  task automatic ack_now();
    ack_at = cyc;
    tick();
  endtask

  int t_fall, f0, o0, p0, gap;
  logic [7:0] rb;
  logic stop_v, pflip;

  initial begin
    // reset with idle line
    rst = 1'b1; Rx = 1'b1;
    repeat (3) tick();
    chk_en = 1'b1;
    chk_d("rst Data_Out", int'(Data_Out), 0);
    chk_d("rst Byte_valid", int'(Byte_valid), 0);
    chk_d("rst errs", int'({Framing_err, Parity_err, Overrun_err}), 0);
    rst = 1'b0;
    repeat (5) tick();

    // 8'h24, exact latency, ack clears next cycle
    t_fall = cyc;
    send_frame(8'h24);
    repeat (4) tick();
    chk_d("h24 latency", t_rise - t_fall, LAT);
    chk_d("h24 Data_Out", int'(Data_Out), 'h24);
    chk_d("h24 Byte_valid", int'(Byte_valid), 1);
    ack_now();
    chk_d("ack clears", int'(Byte_valid), 0);

    // start glitch then 8'hA5
    f0 = ferr_cnt;
    Rx = 1'b0; repeat (4) tick(); Rx = 1'b1;
    repeat (30) tick();
    chk_d("glitch no valid", int'(Byte_valid), 0);
    send_frame(8'hA5);
    repeat (4) tick();
    chk_d("post-glitch A5", int'(Data_Out), 'hA5);
    chk_d("glitch no ferr", ferr_cnt - f0, 0);
    ack_now(); tick();

    // framing error with line held low
    f0 = ferr_cnt;
    send_bits(8'h81, 1'b0, 1'b0, FRAME_BITS);
    repeat (40) tick();
    chk_d("break no valid", int'(Byte_valid), 0);
    Rx = 1'b1;
    repeat (30) tick();
    chk_d("single ferr", ferr_cnt - f0, 1);
    send_frame(8'h7E);
    repeat (4) tick();
    chk_d("post-break 7E", int'(Data_Out), 'h7E);
    ack_now(); tick();

    // reset mid-frame
    f0 = ferr_cnt; o0 = oerr_cnt; p0 = perr_cnt;
    send_bits(8'hC3, 1'b1, 1'b0, 5);
    rst = 1'b1; Rx = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    chk_d("midrst valid", int'(Byte_valid), 0);
    send_frame(8'h5A);
    repeat (4) tick();
    chk_d("midrst errs", (ferr_cnt - f0) + (oerr_cnt - o0) + (perr_cnt - p0), 0);
    chk_d("post-rst 5A", int'(Data_Out), 'h5A);
    ack_now(); tick();

    // back-to-back, no ack: overrun keeps A5
    o0 = oerr_cnt;
    send_frame(8'hA5);
    send_frame(8'h3C);
    repeat (4) tick();
    chk_d("overrun keeps A5", int'(Data_Out), 'hA5);
    chk_d("overrun pulses", oerr_cnt - o0, 1);
    ack_now(); tick();

    // back-to-back with ack on the completion cycle
    o0 = oerr_cnt;
    ack_at = cyc + FRAME_BITS * CPB + LAT - 1;
    send_frame(8'hA5);
    send_frame(8'h3C);
    repeat (4) tick();
    chk_d("ack-timed 3C", int'(Data_Out), 'h3C);
    chk_d("ack-timed valid", int'(Byte_valid), 1);
    chk_d("ack-timed no overrun", oerr_cnt - o0, 0);
    ack_now(); tick();

`ifdef UART_RX_PARITY_EN
    p0 = perr_cnt;
    send_bits(8'h24, 1'b1, 1'b1, FRAME_BITS);
    Rx = 1'b1;
    repeat (4) tick();
    chk_d("bad parity pulse", perr_cnt - p0, 1);
    chk_d("bad parity no valid", int'(Byte_valid), 0);
`endif

    // randomized traffic with random acks
    rand_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        Rx = 1'b0;
        repeat ($urandom_range(1, H - 1)) tick();
        Rx = 1'b1;
        repeat (H + 2) tick();
      end else begin
        rb     = 8'($urandom);
        stop_v = ($urandom_range(0, 7) != 0);
        pflip  = (PAR == 1) && ($urandom_range(0, 5) == 0);
        send_bits(rb, stop_v, pflip, FRAME_BITS);
        Rx  = 1'b1;
        gap = stop_v ? $urandom_range(0, 12) : $urandom_range(2, 12);
        repeat (gap) tick();
      end
    end
    rand_en = 1'b0;
    repeat (3 * CPB) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk_m + n_chk_d, n_fail_m + n_fail_d);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Receive side of the UART link: recovers 8-bit bytes from the serial line driven by the UART transmitter. Each frame is one start bit, 8 data bits LSB-first, an optional parity bit and one stop bit. The block synchronizes the asynchronous line, samples each bit at mid-bit, and holds each received byte behind a valid/ack handshake. It sits between the Rx pin and the byte-consuming logic, at the same bit rate and clock as the transmitter.

## Interface
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range ≥ 4, even values only.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- Rx  input  1  serial line; idle high; asynchronous to clk.
- Byte_ack  input  1  consumer accepts Data_Out; sampled only while Byte_valid = 1.
- Data_Out  output  8  last received byte; stable while Byte_valid = 1.
- Byte_valid  output  1  level; high from byte load until the cycle after Byte_ack.
- Framing_err  output  1  one-cycle pulse: stop bit sampled 0.
- Parity_err  output  1  one-cycle pulse: parity mismatch (see Configuration).
- Overrun_err  output  1  one-cycle pulse: new byte completed while previous one unacknowledged.

## Operation
- Rx passes through a 2-flop synchronizer to give rx_s. All decisions use rx_s.
- States: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: if rx_s = 0, clear the bit counter and go to START.
- START: count CLKS_PER_BIT/2 cycles, then resample rx_s.
  - 0: go to DATA.
  - 1 (glitch): go to IDLE with no output.
- DATA: sample rx_s every CLKS_PER_BIT cycles and shift it into a shift register, LSB first. After the 8th sample, go to PARITY (macro build) or STOP.
- PARITY: sample once after CLKS_PER_BIT cycles, then go to STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - rx_s = 1 and parity OK: byte completes; go to IDLE.
  - rx_s = 0: pulse Framing_err, discard the byte, go to BREAK.
  - Parity mismatch: pulse Parity_err, discard the byte, go to IDLE.
  - If both errors occur, pulse both and go to BREAK.
- BREAK: wait for rx_s = 1, then go to IDLE.
- Byte completion rules:
  - Byte_valid = 0: load Data_Out and set Byte_valid.
  - Byte_valid = 1 with Byte_ack = 1 in the same cycle: load the new byte; Byte_valid stays 1.
  - Byte_valid = 1 with Byte_ack = 0: drop the new byte; Data_Out and Byte_valid are unchanged; pulse Overrun_err.
- Byte_ack with Byte_valid = 1 and no completion: Byte_valid clears next cycle. Byte_ack while Byte_valid = 0 is ignored.
- Bit counter is $clog2(CLKS_PER_BIT) bits wide and resets to 0 at every state entry. Data index is 3 bits.

## Timing
- Reset: state IDLE. Data_Out = 8'h00. Byte_valid, Framing_err, Parity_err, Overrun_err = 0. Shift register and counters = 0.
- Reset asserted mid-frame aborts the frame immediately with no error pulse. After release, reception resumes at the next falling edge of rx_s.
- Rx to rx_s: 2 cycles.
- Let T0 be the first cycle with rx_s = 0 in IDLE. Sample points:
  - Start check: T0 + CLKS_PER_BIT/2.
  - Data bit k: T0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
  - Stop bit: T0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT, or 10·CLKS_PER_BIT with parity.
- Byte_valid, Data_Out and all error pulses are registered: they appear one cycle after the stop sample.
- Returning to IDLE at mid stop bit allows back-to-back frames with zero idle time.

## Configuration
- UART_RX_PARITY_EN defined:
  - PARITY state is present; frames carry an even-parity bit after data bit 7.
  - A mismatch pulses Parity_err.
- UART_RX_PARITY_EN undefined:
  - Frames have no parity bit; DATA goes directly to STOP.
  - Parity_err is tied to 0.

## Test plan
- Reset: hold rst for 3 cycles with Rx = 1 -> all outputs 0; assert rst mid-frame -> no Byte_valid or error pulse, and the next full frame is received correctly.
- Receive 8'h24 at CLKS_PER_BIT = 16, no parity -> Data_Out = 8'h24; Byte_valid rises exactly 2 + 8 + 144 + 1 cycles after the Rx falling edge; Byte_ack clears it the following cycle.
- Rx pulsed low for 4 cycles -> no Byte_valid, no error; a following 8'hA5 frame is received correctly.
- Stop bit driven 0, Rx held low 40 cycles, then high -> single Framing_err pulse, Byte_valid = 0; no new frame starts until Rx returns high.
- Back-to-back 8'hA5, 8'h3C with no ack -> Data_Out = 8'hA5 and one Overrun_err pulse; repeat with Byte_ack timed to the completion cycle -> Data_Out = 8'h3C, Byte_valid stays 1.
- Parity build, 8'h24 sent with parity bit 1 -> Parity_err pulse, no Byte_valid; parity bit 0 -> Data_Out = 8'h24. Non-parity build -> Parity_err constant 0.
